// File: rtl/risc16_pkg.sv
// Shared types for the RISC16 data-memory arbiter.
package risc16_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

endpackage

// File: rtl/risc16_mem_arbiter_if.sv
// Requester-side access port: request/address/data out, grant/done/read data back.
interface risc16_mem_arbiter_if
    import risc16_pkg::*;
#(
    parameter int ADDR_W = 8
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              gnt;
    logic              done;
    logic [WORD_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, done, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, done, rdata
    );

endinterface

// File: rtl/risc16_rr_arb2.sv
// Two-way arbiter: picks the CPU or the loader, with an optional fixed CPU priority.
module risc16_rr_arb2
    import risc16_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       fixed_prio,
    input  logic       advance,
    output owner_t     winner,
    output logic       any
);

    owner_t ptr;

    assign any = |req;

    // Winner selection: a lone requester wins, a conflict goes to the CPU or to the pointer.
    always_comb begin
        winner = OWN_CPU;
        if (req == 2'b11) begin
            winner = (fixed_prio || (ptr == OWN_CPU)) ? OWN_CPU : OWN_LDR;
        end else if (req[1]) begin
            winner = OWN_LDR;
        end
    end

    // Pointer moves to the port that lost; it is only consulted in IDLE, so
    // updating it on the grant edge is indistinguishable from updating it after ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= OWN_CPU;
        end else if (advance) begin
            ptr <= (winner == OWN_CPU) ? OWN_LDR : OWN_CPU;
        end
    end

endmodule

// File: rtl/risc16_mem_arbiter.sv
// Shares the single-port RISC16 data memory between the CPU load/store unit and the loader.
module risc16_mem_arbiter
    import risc16_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int MEM_LAT  = 1,
    parameter int CPU_PRIO = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    risc16_mem_arbiter_if.slave  cpu,
    risc16_mem_arbiter_if.slave  ldr,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_W-1:0]    mem_wdata,
    input  logic [WORD_W-1:0]    mem_rdata,
    output logic                 busy
);

    state_t            state;
    owner_t            owner;
    owner_t            winner;
    logic              any;
    logic              acc_we;
    logic [2:0]        cnt;
    logic              cpu_gnt_q;
    logic              ldr_gnt_q;
    logic              cpu_done_q;
    logic              ldr_done_q;
    logic [WORD_W-1:0] cpu_rdata_q;
    logic [WORD_W-1:0] ldr_rdata_q;
    logic              advance;

    assign advance = (state == IDLE) && any;

    risc16_rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        ({ldr.req, cpu.req}),
        .fixed_prio (CPU_PRIO != 0),
        .advance    (advance),
        .winner     (winner),
        .any        (any)
    );

    assign cpu.gnt   = cpu_gnt_q;
    assign cpu.done  = cpu_done_q;
    assign cpu.rdata = cpu_rdata_q;
    assign ldr.gnt   = ldr_gnt_q;
    assign ldr.done  = ldr_done_q;
    assign ldr.rdata = ldr_rdata_q;
    assign busy      = (state != IDLE);

    // Per-access sequencer; every output is registered and pulses default back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_CPU;
            acc_we      <= 1'b0;
            cnt         <= '0;
            cpu_gnt_q   <= 1'b0;
            ldr_gnt_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            ldr_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            cpu_gnt_q  <= 1'b0;
            ldr_gnt_q  <= 1'b0;
            cpu_done_q <= 1'b0;
            ldr_done_q <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        owner  <= winner;
                        mem_en <= 1'b1;
                        state  <= ISSUE;
                        if (winner == OWN_LDR) begin
                            acc_we    <= ldr.we;
                            mem_we    <= ldr.we;
                            mem_addr  <= ldr.addr;
                            mem_wdata <= ldr.wdata;
                            ldr_gnt_q <= 1'b1;
                        end else begin
                            acc_we    <= cpu.we;
                            mem_we    <= cpu.we;
                            mem_addr  <= cpu.addr;
                            mem_wdata <= cpu.wdata;
                            cpu_gnt_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= 3'(MEM_LAT - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        if (!acc_we) begin
                            if (owner == OWN_LDR) begin
                                ldr_rdata_q <= mem_rdata;
                            end else begin
                                cpu_rdata_q <= mem_rdata;
                            end
                        end
                        if (owner == OWN_LDR) begin
                            ldr_done_q <= 1'b1;
                        end else begin
                            cpu_done_q <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// Directed bench: three arbiter instances (round-robin/lat 1, CPU priority/lat 1, round-robin/lat 3).
module tb_risc16_mem_arbiter;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    risc16_mem_arbiter_if #(.ADDR_W(8)) cpu_a ();
    risc16_mem_arbiter_if #(.ADDR_W(8)) ldr_a ();
    risc16_mem_arbiter_if #(.ADDR_W(8)) cpu_b ();
    risc16_mem_arbiter_if #(.ADDR_W(8)) ldr_b ();
    risc16_mem_arbiter_if #(.ADDR_W(8)) cpu_c ();
    risc16_mem_arbiter_if #(.ADDR_W(8)) ldr_c ();

    logic        mem_en_a, mem_we_a, busy_a;
    logic [7:0]  mem_addr_a;
    logic [15:0] mem_wdata_a, mem_rdata_a;
    logic        mem_en_b, mem_we_b, busy_b;
    logic [7:0]  mem_addr_b;
    logic [15:0] mem_wdata_b, mem_rdata_b;
    logic        mem_en_c, mem_we_c, busy_c;
    logic [7:0]  mem_addr_c;
    logic [15:0] mem_wdata_c, mem_rdata_c;

    risc16_mem_arbiter #(.ADDR_W(8), .MEM_LAT(1), .CPU_PRIO(0)) u_a (
        .clk(clk), .rst(rst), .cpu(cpu_a), .ldr(ldr_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .busy(busy_a)
    );
    risc16_mem_arbiter #(.ADDR_W(8), .MEM_LAT(1), .CPU_PRIO(1)) u_b (
        .clk(clk), .rst(rst), .cpu(cpu_b), .ldr(ldr_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
    );
    risc16_mem_arbiter #(.ADDR_W(8), .MEM_LAT(3), .CPU_PRIO(0)) u_c (
        .clk(clk), .rst(rst), .cpu(cpu_c), .ldr(ldr_c),
        .mem_en(mem_en_c), .mem_we(mem_we_c), .mem_addr(mem_addr_c),
        .mem_wdata(mem_wdata_c), .mem_rdata(mem_rdata_c), .busy(busy_c)
    );

    // Memory models: registered read, MEM_LAT stages deep, 0 when not strobed.
    logic [15:0] ram_a [256];
    logic [15:0] ram_b [256];
    logic [15:0] ram_c [256];
    logic [15:0] pipe_a, pipe_b;
    logic [15:0] pipe_c [3];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                ram_a[i] <= 16'h0;
                ram_b[i] <= 16'h0;
                ram_c[i] <= 16'h0;
            end
            ram_a[8'h10] <= 16'hAAAA;
            ram_a[8'h20] <= 16'h5555;
            ram_b[8'h10] <= 16'hAAAA;
            ram_b[8'h20] <= 16'h5555;
            ram_c[8'h7F] <= 16'hBEEF;
            pipe_a <= 16'h0;
            pipe_b <= 16'h0;
            for (int i = 0; i < 3; i++) pipe_c[i] <= 16'h0;
        end else begin
            if (mem_en_a && mem_we_a) ram_a[mem_addr_a] <= mem_wdata_a;
            if (mem_en_b && mem_we_b) ram_b[mem_addr_b] <= mem_wdata_b;
            if (mem_en_c && mem_we_c) ram_c[mem_addr_c] <= mem_wdata_c;
            pipe_a    <= mem_en_a ? ram_a[mem_addr_a] : 16'h0;
            pipe_b    <= mem_en_b ? ram_b[mem_addr_b] : 16'h0;
            pipe_c[0] <= mem_en_c ? ram_c[mem_addr_c] : 16'h0;
            pipe_c[1] <= pipe_c[0];
            pipe_c[2] <= pipe_c[1];
        end
    end

    assign mem_rdata_a = pipe_a;
    assign mem_rdata_b = pipe_b;
    assign mem_rdata_c = pipe_c[2];

    logic [62:0] outs_a, outs_b, outs_c;
    assign outs_a = {cpu_a.gnt, cpu_a.done, cpu_a.rdata, ldr_a.gnt, ldr_a.done, ldr_a.rdata,
                     mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a, busy_a};
    assign outs_b = {cpu_b.gnt, cpu_b.done, cpu_b.rdata, ldr_b.gnt, ldr_b.done, ldr_b.rdata,
                     mem_en_b, mem_we_b, mem_addr_b, mem_wdata_b, busy_b};
    assign outs_c = {cpu_c.gnt, cpu_c.done, cpu_c.rdata, ldr_c.gnt, ldr_c.done, ldr_c.rdata,
                     mem_en_c, mem_we_c, mem_addr_c, mem_wdata_c, busy_c};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        cpu_a.req = 0; cpu_a.we = 0; cpu_a.addr = '0; cpu_a.wdata = '0;
        ldr_a.req = 0; ldr_a.we = 0; ldr_a.addr = '0; ldr_a.wdata = '0;
        cpu_b.req = 0; cpu_b.we = 0; cpu_b.addr = '0; cpu_b.wdata = '0;
        ldr_b.req = 0; ldr_b.we = 0; ldr_b.addr = '0; ldr_b.wdata = '0;
        cpu_c.req = 0; cpu_c.we = 0; cpu_c.addr = '0; cpu_c.wdata = '0;
        ldr_c.req = 0; ldr_c.we = 0; ldr_c.addr = '0; ldr_c.wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: everything quiet.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_outs_a", outs_a, 0);
            check("idle_outs_b", outs_b, 0);
            check("idle_outs_c", outs_c, 0);
        end

        // CPU store 0x1234 -> 0x05 on A.
        cpu_a.req = 1; cpu_a.we = 1; cpu_a.addr = 8'h05; cpu_a.wdata = 16'h1234;
        @(negedge clk);
        check("st_cpu_gnt", cpu_a.gnt, 1);
        check("st_ldr_gnt", ldr_a.gnt, 0);
        check("st_mem_en", mem_en_a, 1);
        check("st_mem_we", mem_we_a, 1);
        check("st_mem_addr", mem_addr_a, 8'h05);
        check("st_mem_wdata", mem_wdata_a, 16'h1234);
        cpu_a.req = 0; cpu_a.addr = 8'h99; cpu_a.wdata = 16'hFFFF;
        @(negedge clk);
        check("st_wait_done", cpu_a.done, 0);
        check("st_wait_mem_en", mem_en_a, 0);
        check("st_wait_mem_addr", mem_addr_a, 0);
        check("st_wait_busy", busy_a, 1);
        @(negedge clk);
        check("st_done", cpu_a.done, 1);
        check("st_rdata_kept", cpu_a.rdata, 0);
        @(negedge clk);
        check("st_idle_busy", busy_a, 0);
        check("st_idle_done", cpu_a.done, 0);

        // CPU load of 0x05 returns the stored word.
        cpu_a.req = 1; cpu_a.we = 0; cpu_a.addr = 8'h05;
        @(negedge clk);
        check("ld_cpu_gnt", cpu_a.gnt, 1);
        check("ld_mem_we", mem_we_a, 0);
        cpu_a.req = 0;
        @(negedge clk);
        @(negedge clk);
        check("ld_done", cpu_a.done, 1);
        check("ld_rdata", cpu_a.rdata, 16'h1234);
        check("ld_ldr_rdata", ldr_a.rdata, 0);
        check("ld_ldr_done", ldr_a.done, 0);
        @(negedge clk);
        check("ld_rdata_held", cpu_a.rdata, 16'h1234);

        // Round-robin with both requesters loading continuously.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cpu_a.req = 1; cpu_a.we = 0; cpu_a.addr = 8'h10;
        ldr_a.req = 1; ldr_a.we = 0; ldr_a.addr = 8'h20;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("rr_cpu_gnt", cpu_a.gnt, (k % 8 == 1));
            check("rr_ldr_gnt", ldr_a.gnt, (k % 8 == 5));
            check("rr_cpu_done", cpu_a.done, (k % 8 == 3));
            check("rr_ldr_done", ldr_a.done, (k % 8 == 7));
            check("rr_cpu_rdata", cpu_a.rdata, (k >= 3) ? 16'hAAAA : 16'h0);
            check("rr_ldr_rdata", ldr_a.rdata, (k >= 7) ? 16'h5555 : 16'h0);
        end
        cpu_a.req = 0; ldr_a.req = 0;

        // Fixed CPU priority on B.
        cpu_b.req = 1; cpu_b.we = 0; cpu_b.addr = 8'h10;
        ldr_b.req = 1; ldr_b.we = 0; ldr_b.addr = 8'h20;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check("fp_cpu_gnt", cpu_b.gnt, (k == 1 || k == 5 || k == 9));
            check("fp_ldr_gnt", ldr_b.gnt, (k == 13));
            check("fp_cpu_done", cpu_b.done, (k == 3 || k == 7 || k == 11));
            check("fp_ldr_done", ldr_b.done, (k == 15));
            if (k == 12) cpu_b.req = 0;
            if (k == 13) begin
                check("fp_ldr_addr", mem_addr_b, 8'h20);
                ldr_b.req = 0;
            end
        end
        check("fp_ldr_rdata", ldr_b.rdata, 16'h5555);
        check("fp_cpu_rdata", cpu_b.rdata, 16'hAAAA);

        // Loader load with MEM_LAT=3 on C.
        ldr_c.req = 1; ldr_c.we = 0; ldr_c.addr = 8'h7F;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("l3_busy", busy_c, (k >= 1 && k <= 5));
            check("l3_ldr_gnt", ldr_c.gnt, (k == 1));
            check("l3_mem_en", mem_en_c, (k == 1));
            check("l3_ldr_done", ldr_c.done, (k == 5));
            check("l3_ldr_rdata", ldr_c.rdata, (k >= 5) ? 16'hBEEF : 16'h0);
            check("l3_cpu_done", cpu_c.done, 0);
            if (k == 1) begin
                check("l3_mem_addr", mem_addr_c, 8'h7F);
                ldr_c.req = 0;
            end
        end

        // Reset in WAIT of a CPU load on A.
        @(negedge clk);
        cpu_a.req = 1; cpu_a.we = 0; cpu_a.addr = 8'h10;
        @(negedge clk);
        check("rw_cpu_gnt", cpu_a.gnt, 1);
        cpu_a.req = 0;
        @(negedge clk);
        check("rw_wait_busy", busy_a, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rw_outs_zero", outs_a, 0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rw_no_done", cpu_a.done, 0);
            check("rw_idle", busy_a, 0);
        end
        ldr_a.req = 1; ldr_a.we = 0; ldr_a.addr = 8'h20;
        @(negedge clk);
        check("rw_ldr_gnt", ldr_a.gnt, 1);
        check("rw_ldr_addr", mem_addr_a, 8'h20);
        check("rw_cpu_gnt0", cpu_a.gnt, 0);
        ldr_a.req = 0;
        @(negedge clk);
        @(negedge clk);
        check("rw_ldr_done", ldr_a.done, 1);
        check("rw_ldr_rdata", ldr_a.rdata, 16'h5555);
        check("rw_cpu_rdata", cpu_a.rdata, 0);
        check("rw_cpu_done", cpu_a.done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/risc16_mem_arbiter.md
Name: risc16_mem_arbiter

Overview:
Shares the RISC16 single-port data memory (mem[]) between two requesters: the CPU load/store unit (port cpu_) and the program/debug loader (port ldr_).
- Serialises accesses with a per-access state machine and a round-robin or fixed-priority grant.
- Captures read data and returns a one-cycle completion pulse to the winning requester.
- Sits between the cpu datapath and the data RAM.

Parameters:
ADDR_W, 8, data-memory word-address width
MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata (legal range 1..7)
CPU_PRIO, 0, 1 = CPU always wins a conflict; 0 = round-robin

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
cpu_req  in  1  CPU access request; held stable until cpu_gnt
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  16  store data
cpu_gnt  out  1  one-cycle pulse: request accepted and issued to memory
cpu_done  out  1  one-cycle pulse: access complete
cpu_rdata  out  16  load data, valid while cpu_done=1, held until next CPU load completes
ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_done, ldr_rdata: same directions, widths and meaning for the loader
mem_en  out  1  memory access strobe (one cycle per access)
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset: state=IDLE, rr pointer=CPU. All outputs 0, including rdata, gnt, done, mem_*.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample cpu_req/ldr_req at the edge.
  - If exactly one is high, that requester wins.
  - If both are high, the winner is the CPU when CPU_PRIO=1; otherwise the rr pointer's port.
  - On a win, latch owner, we, addr and wdata; go to ISSUE.
  - If neither is high, stay in IDLE.
- ISSUE (1 cycle):
  - mem_en=1; mem_we/addr/wdata from latched values.
  - Owner's gnt=1.
  - rr pointer moves to the non-owner at the end of this cycle.
  - Load wait counter with MEM_LAT-1; go to WAIT.
- WAIT: counter decrements each cycle. When counter==0, capture mem_rdata (if load) into owner's rdata register, then go to RESP.
  - With MEM_LAT=1, WAIT lasts exactly 1 cycle.
- RESP (1 cycle): owner's done=1; go to IDLE.
- Stores take the same path and timing as loads; rdata is unchanged by a store.
- Latency: req seen at edge T means gnt/mem_en in cycle T+1, done in cycle T+2+MEM_LAT. One access per 3+MEM_LAT cycles.
- Requester rules:
  - A requester must deassert req, or present a new request, in the cycle after gnt.
  - req is ignored outside IDLE.
  - addr/we/wdata are sampled only at the IDLE edge; later changes have no effect.
- mem_we/mem_addr/mem_wdata return to 0 outside ISSUE.
- The non-owner's gnt, done and rdata are never disturbed.
- Requests arriving during ISSUE/WAIT/RESP are held by the requester and arbitrated in the next IDLE cycle.
- rst asserted in any state: IDLE next cycle, all outputs 0.
  - A store already strobed is not retracted.
  - The pending done is dropped; no late done after reset.
  - rr pointer returns to CPU.
- Address/data widths are pass-through; no arithmetic other than the 3-bit wait counter.

Decomposition:
- risc16_pkg: state enum (IDLE, ISSUE, WAIT, RESP), WORD_W=16, owner IDs (OWN_CPU=0, OWN_LDR=1).
- One sub-module, risc16_rr_arb2: 2-way arbiter holding the pointer. Inputs: clk, rst, req[1:0], fixed_prio, advance. Outputs: winner, any.

Test Plan:
- Reset then idle, no req for 10 cycles -> busy=0 and all outputs 0 throughout.
- CPU store: cpu_req=1, we=1, addr=0x05, wdata=0x1234 at edge T.
  - -> cpu_gnt and mem_en/mem_we=1 with mem_addr=0x05, mem_wdata=0x1234 in T+1.
  - -> cpu_done in T+3 (MEM_LAT=1).
  - -> a following load of 0x05 returns cpu_rdata=0x1234 with cpu_done.
- Simultaneous requests, CPU_PRIO=0: both req continuously, both loads.
  - -> grants alternate CPU, LDR, CPU, LDR at 4-cycle spacing.
  - -> each done is seen only on the owner port; the other port's rdata is unchanged.
- CPU_PRIO=1, both req held -> CPU granted every access and ldr_gnt never asserts. Dropping cpu_req -> ldr_gnt in the next ISSUE.
- MEM_LAT=3, loader load of addr 0x7F where memory returns 0xBEEF three cycles after mem_en -> ldr_done in T+5 with ldr_rdata=0xBEEF; busy high for 5 cycles.
- rst pulsed in WAIT of a CPU load -> next cycle IDLE with outputs 0, no cpu_done ever. A new ldr_req is then granted normally, since the pointer is reset to CPU and the CPU is idle.
